spi_ecc_regbank: RTL and testbench
==================================

Name: spi_ecc_regbank

Overview:
- Parametrised SPI-slave register bank that sits between the ESP32 SPI master and a WIDTH-bit ECC point-multiplication core.
- Oversamples SPI in the single system clock domain and holds N_IN operand slots and N_OUT result slots.
- Supports multi-byte burst access with auto-increment addressing, readback of all slots, and a start/busy/done/error control-status pair.
- Supersedes the fixed 128-bit, single-byte-per-transaction wrapper.

Parameters:
WIDTH, 128, operand/result width in bits; must be a multiple of 8; BYTES = WIDTH/8
N_IN, 4, input operand slots (x, y, k, b)
N_OUT, 2, result slots (dx, dy)
SYNC_STAGES, 2, synchroniser depth for spi_sclk/spi_mosi/spi_cs_n; must be >= 2
Constraint: (N_IN+N_OUT)*BYTES <= 126

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
spi_sclk  in  1  SPI clock, mode 0, at most clk/8
spi_mosi  in  1  SPI data in, MSB first
spi_cs_n  in  1  SPI chip select, active low
spi_miso  out  1  SPI data out
core_din  out  N_IN*WIDTH  operand slots; slot s occupies bits [s*WIDTH +: WIDTH]
core_start  out  1  one-cycle start pulse to the core
core_dout  in  N_OUT*WIDTH  core results, same packing as core_din
core_done  in  1  one-cycle completion pulse from the core
done_gpio  out  1  level; mirrors the status done bit
busy_gpio  out  1  level; mirrors the status busy bit

Behaviour:
Reset:
- rst_n low asynchronously clears all slots, result regs, busy, done, err, and the SPI FSM.
- All outputs are 0 during reset, including spi_miso and core_start.

Synchronisation:
- spi_sclk, spi_mosi and spi_cs_n each pass through SYNC_STAGES flops.
- Rise and fall edges of sclk are detected from the last two sync stages.
- All SPI logic runs in clk only; spi_sclk is never used as a clock.

SPI FSM states:
- IDLE: cs_n high.
- CMD: first byte after cs_n falls. Bit7 = R/nW; bits[6:0] = start address.
- DATA: every following byte. The address increments after each data byte and wraps 0x7F -> 0x00.

Receive path:
- On each sclk rise, mosi is shifted into the rx register and bit_cnt (3 bits) increments.
- When bit_cnt wraps 7 -> 0, the byte is complete.

Write path:
- A complete DATA byte in write mode commits to the current address within SYNC_STAGES+1 clk of the 8th sclk rise at the pin.

Read path (mode 0):
- On each sclk fall in read mode: if bit_cnt == 0, the tx register loads the byte at the current address; otherwise it shifts left.
- spi_miso = tx[7] while cs_n is low, and 0 while cs_n is high.

Address map:
- Input slot s, byte b: s*BYTES + b. Little-endian: offset 0 is bits [7:0].
- Result slot r, byte b: (N_IN+r)*BYTES + b. Read-only.
- 0x7E CTRL (write): bit0 start, bit1 clear_done, bit2 clear_err. Reads as 0x00.
- 0x7F STATUS (read): {5'b0, err, done, busy}. Writes are ignored.
- Unmapped address: reads return 0x00; writes are ignored.

Control rules:
- A start write when busy = 0:
  - busy <= 1, done <= 0, core_start pulses for exactly one cycle.
  - A start write when busy = 1 is ignored and sets err.
- A write to any input slot while busy = 1 is dropped and sets err. This keeps core_din stable for the whole computation.
- core_done while busy = 1: latch core_dout into the result regs, busy <= 0, done <= 1 in the same cycle.
- core_done while busy = 0 is ignored.
- clear_done and core_done in the same cycle: done ends at 1.
- clear_err and an error event in the same cycle: err ends at 1.

Boundary conditions:
- cs_n rising mid-byte: the partial byte is discarded, bit_cnt clears, FSM returns to IDLE, and no commit occurs.
- A CMD byte alone (no data bytes) has no effect.
- Burst length is unlimited; the address wraps.
- Reset mid-computation drops busy; a later core_done is ignored.

Test Plan:
1. Write burst: cmd 0x00 followed by 64 bytes 0x01..0x40 (WIDTH=128, N_IN=4) -> core_din[7:0] = 0x01, core_din[511:504] = 0x40; read back 0x80 + 64 bytes -> identical data on miso.
2. Start: write 0x7E = 0x01 -> core_start high for exactly 1 clk, STATUS = 0x01. Drive core_dout = {dy=0xA5.., dx=0x3C..} with core_done -> STATUS = 0x02, done_gpio = 1. Read 0xC0 (addr 0x40) for 32 bytes -> dx bytes then dy bytes.
3. While busy: write slot 0 byte 0 = 0xFF and write start again -> core_din unchanged, no second core_start, STATUS = 0x05. Write 0x7E = 0x04 -> err = 0.
4. Abort: cs_n raised after 5 bits of a data byte to addr 0x10 -> byte 0x10 unchanged. The next transaction parses its first byte as a command.
5. Wrap: read starting at 0x7F for 3 bytes -> STATUS, then byte 0x00, then byte 0x01.
6. Async reset asserted while busy with a partial byte in flight -> all outputs 0 immediately. After release, STATUS = 0x00 and a stray core_done leaves done = 0.

Source files
------------

// File: rtl/spi_ecc_regbank.sv
// SPI-slave register bank feeding a WIDTH-bit ECC point-multiply core.
// SPI is oversampled in clk; burst access with auto-incrementing address.
module spi_ecc_regbank #(
    parameter int WIDTH       = 128,
    parameter int N_IN        = 4,
    parameter int N_OUT       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   spi_sclk,
    input  logic                   spi_mosi,
    input  logic                   spi_cs_n,
    output logic                   spi_miso,
    output logic [N_IN*WIDTH-1:0]  core_din,
    output logic                   core_start,
    input  logic [N_OUT*WIDTH-1:0] core_dout,
    input  logic                   core_done,
    output logic                   done_gpio,
    output logic                   busy_gpio
);
    localparam int BYTES = WIDTH / 8;
    localparam int IN_B  = N_IN * BYTES;
    localparam int RES_B = N_OUT * BYTES;
    localparam logic [6:0] CTRL = 7'h7E;
    localparam logic [6:0] STAT = 7'h7F;

    if ((WIDTH % 8) != 0 || SYNC_STAGES < 2 || IN_B + RES_B > 126) begin : g_chk
        $error("spi_ecc_regbank: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    logic [SYNC_STAGES-1:0] sclk_q, mosi_q, cs_q;
    logic                   rise, fall, mosi_s, cs_s;

    state_t     state;
    logic       rw;
    logic [6:0] addr;
    logic [2:0] bit_cnt;
    logic [7:0] rx, tx;

    logic [N_IN*WIDTH-1:0]  din_q;
    logic [N_OUT*WIDTH-1:0] res_q;
    logic                   busy, done, err, start_q;

    logic [7:0] rx_byte, rd_byte;
    logic       byte_end, wr_fire, wr_in, wr_ctl;
    logic       start_req, start_ok, err_evt, done_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            mosi_q <= '0;
            cs_q   <= '1;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
        end
    end

    assign rise   = sclk_q[SYNC_STAGES-2] & ~sclk_q[SYNC_STAGES-1];
    assign fall   = ~sclk_q[SYNC_STAGES-2] & sclk_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];
    assign cs_s   = cs_q[SYNC_STAGES-1];

    assign rx_byte   = {rx[6:0], mosi_s};
    assign byte_end  = ~cs_s & rise & (bit_cnt == 3'd7);
    assign wr_fire   = byte_end & (state == DATA) & ~rw;
    assign wr_in     = wr_fire & (int'(addr) < IN_B);
    assign wr_ctl    = wr_fire & (addr == CTRL);
    assign start_req = wr_ctl & rx_byte[0];
    assign start_ok  = start_req & ~busy;
    assign err_evt   = busy & (wr_in | start_req);
    assign done_evt  = core_done & busy;

    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < IN_B; i++)
            if (addr == 7'(i)) rd_byte = din_q[i*8 +: 8];
        for (int i = 0; i < RES_B; i++)
            if (addr == 7'(IN_B + i)) rd_byte = res_q[i*8 +: 8];
        if (addr == STAT) rd_byte = {5'b0, err, done, busy};
    end

    // First completed byte after cs_n falls is the command, the rest are data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rw      <= 1'b0;
            addr    <= '0;
            bit_cnt <= '0;
            rx      <= '0;
            tx      <= '0;
        end else if (cs_s) begin
            state   <= IDLE;
            bit_cnt <= '0;
            rx      <= '0;
            tx      <= '0;
        end else begin
            if (state == IDLE) state <= CMD;
            if (rise) begin
                rx      <= rx_byte;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (state == DATA) begin
                        addr <= addr + 7'd1;
                    end else begin
                        rw    <= rx_byte[7];
                        addr  <= rx_byte[6:0];
                        state <= DATA;
                    end
                end
            end
            if (fall && state == DATA && rw)
                tx <= (bit_cnt == 3'd0) ? rd_byte : {tx[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q   <= '0;
            res_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= start_ok;
            // Operands are frozen while the core is computing.
            for (int i = 0; i < IN_B; i++)
                if (wr_in && !busy && addr == 7'(i))
                    din_q[i*8 +: 8] <= rx_byte;
            if (done_evt) begin
                res_q <= core_dout;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else if (start_ok) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (wr_ctl && rx_byte[1]) begin
                done <= 1'b0;
            end
            if (err_evt) err <= 1'b1;
            else if (wr_ctl && rx_byte[2]) err <= 1'b0;
        end
    end

    assign core_din   = din_q;
    assign core_start = start_q;
    assign done_gpio  = done;
    assign busy_gpio  = busy;
    assign spi_miso   = tx[7] & ~spi_cs_n;

endmodule

// File: tb/tb_spi_ecc_regbank.sv
// Randomised scoreboard bench for spi_ecc_regbank.
// A byte-level register model predicts every miso byte and status output.
module tb_spi_ecc_regbank;
    localparam int WIDTH = 128;
    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int SYNC  = 2;
    localparam int BYTES = WIDTH / 8;
    localparam int IN_B  = N_IN * BYTES;
    localparam int RES_B = N_OUT * BYTES;
    localparam int DW    = N_IN * WIDTH;
    localparam int RW    = N_OUT * WIDTH;
    localparam int H     = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_sclk = 1'b0;
    logic          spi_mosi = 1'b0;
    logic          spi_cs_n = 1'b1;
    logic          spi_miso;
    logic [DW-1:0] core_din;
    logic          core_start;
    logic [RW-1:0] core_dout = '0;
    logic          core_done = 1'b0;
    logic          done_gpio;
    logic          busy_gpio;

    spi_ecc_regbank #(
        .WIDTH(WIDTH), .N_IN(N_IN), .N_OUT(N_OUT), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .spi_miso(spi_miso),
        .core_din(core_din), .core_start(core_start),
        .core_dout(core_dout), .core_done(core_done),
        .done_gpio(done_gpio), .busy_gpio(busy_gpio)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_start = 0;
    int exp_start = 0;

    logic [7:0] m_in [IN_B];
    logic [7:0] m_res[RES_B];
    logic       m_busy, m_done, m_err;
    logic [7:0] exp_q[$];
    logic [7:0] wbuf[$];

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < IN_B; i++) m_in[i] = 8'h00;
        for (int i = 0; i < RES_B; i++) m_res[i] = 8'h00;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    function automatic logic [7:0] m_read(input logic [6:0] a);
        if (int'(a) < IN_B) return m_in[int'(a)];
        if (int'(a) < IN_B + RES_B) return m_res[int'(a) - IN_B];
        if (a == 7'h7F) return {5'b0, m_err, m_done, m_busy};
        return 8'h00;
    endfunction

    task automatic m_write(input logic [6:0] a, input logic [7:0] d);
        if (int'(a) < IN_B) begin
            if (m_busy) m_err = 1'b1;
            else m_in[int'(a)] = d;
        end else if (a == 7'h7E) begin
            if (d[2]) m_err = 1'b0;
            if (d[0] && m_busy) begin
                m_err = 1'b1;
            end else if (d[0]) begin
                m_busy = 1'b1;
                m_done = 1'b0;
                exp_start++;
            end
            if (d[1]) m_done = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] din_model();
        logic [DW-1:0] v;
        for (int i = 0; i < IN_B; i++) v[i*8 +: 8] = m_in[i];
        return v;
    endfunction

    always @(negedge clk) if (core_start) n_start++;

    // Monitor: assembles miso bytes of read transactions, pops expectations.
    initial begin
        int         mbit;
        logic       first, mrd;
        logic [7:0] msh, csh, e;
        mbit = 0; first = 1'b1; mrd = 1'b0; msh = '0; csh = '0;
        forever begin
            @(posedge spi_sclk or posedge spi_cs_n);
            if (spi_cs_n) begin
                mbit  = 0;
                first = 1'b1;
            end else begin
                msh = {msh[6:0], spi_miso};
                csh = {csh[6:0], spi_mosi};
                mbit++;
                if (mbit == 8) begin
                    mbit = 0;
                    if (first) begin
                        first = 1'b0;
                        mrd   = csh[7];
                    end else if (mrd) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL sb_underflow: got %0h expected none", msh);
                        end else begin
                            e = exp_q.pop_front();
                            chk("miso_byte", DW'(msh), DW'(e));
                        end
                    end
                end
            end
        end
    end

    task automatic spi_bits(input logic [7:0] b, input int nb);
        for (int i = 7; i > 7 - nb; i--) begin
            spi_mosi = b[i];
            repeat (H) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (H) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_lo();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic cs_hi();
        repeat (H) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2 * H) @(negedge clk);
    endtask

    task automatic do_write(input logic [6:0] a);
        cs_lo();
        spi_bits({1'b0, a}, 8);
        foreach (wbuf[i]) begin
            spi_bits(wbuf[i], 8);
            m_write(a + 7'(i), wbuf[i]);
        end
        cs_hi();
        wbuf.delete();
    endtask

    task automatic do_read(input logic [6:0] a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(m_read(a + 7'(i)));
        cs_lo();
        spi_bits({1'b1, a}, 8);
        repeat (n) spi_bits(8'($urandom), 8);
        cs_hi();
    endtask

    task automatic core_finish(input logic [RW-1:0] v);
        @(negedge clk);
        core_dout = v;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        if (m_busy) begin
            for (int i = 0; i < RES_B; i++) m_res[i] = v[i*8 +: 8];
            m_busy = 1'b0;
            m_done = 1'b1;
        end
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [RW-1:0] rand_res();
        logic [RW-1:0] v;
        for (int k = 0; k < RW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_state();
        chk("core_din", core_din, din_model());
        chk("busy_gpio", DW'(busy_gpio), DW'(m_busy));
        chk("done_gpio", DW'(done_gpio), DW'(m_done));
        chk("start_count", DW'(n_start), DW'(exp_start));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        int len;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_din", core_din, '0);
        chk("rst_miso", DW'(spi_miso), '0);
        chk("rst_start", DW'(core_start), '0);
        chk("rst_busy", DW'(busy_gpio), '0);
        chk("rst_done", DW'(done_gpio), '0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 1; i <= 64; i++) wbuf.push_back(8'(i));
        do_write(7'h00);
        chk("din_lo", DW'(core_din[7:0]), DW'(8'h01));
        chk("din_hi", DW'(core_din[511:504]), DW'(8'h40));
        check_state();
        do_read(7'h00, 64);

        wbuf.push_back(8'h01);
        do_write(7'h7E);
        check_state();
        do_read(7'h7F, 1);
        core_finish({{BYTES{8'hA5}}, {BYTES{8'h3C}}});
        check_state();
        do_read(7'h7F, 1);
        do_read(7'h40, 32);

        wbuf.push_back(8'h01);
        do_write(7'h7E);
        wbuf.push_back(8'hFF);
        do_write(7'h00);
        wbuf.push_back(8'h01);
        do_write(7'h7E);
        check_state();
        do_read(7'h7F, 1);
        wbuf.push_back(8'h04);
        do_write(7'h7E);
        do_read(7'h7F, 1);
        core_finish(rand_res());

        cs_lo();
        spi_bits(8'h10, 8);
        spi_bits(8'hEE, 5);
        cs_hi();
        do_read(7'h10, 1);
        check_state();

        do_read(7'h7F, 3);

        repeat (16) begin
            op = $urandom_range(0, 3);
            len = $urandom_range(1, 10);
            case (op)
                0: begin
                    repeat (len) wbuf.push_back(8'($urandom));
                    do_write(7'($urandom));
                end
                1: do_read(7'($urandom), len);
                2: core_finish(rand_res());
                default: begin
                    wbuf.push_back(8'($urandom_range(0, 7)));
                    do_write(7'h7E);
                end
            endcase
            check_state();
        end

        core_finish(rand_res());
        wbuf.push_back(8'h01);
        do_write(7'h7E);
        check_state();
        cs_lo();
        spi_bits(8'h00, 8);
        spi_bits(8'h5A, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_din", core_din, '0);
        chk("arst_miso", DW'(spi_miso), '0);
        chk("arst_start", DW'(core_start), '0);
        chk("arst_busy", DW'(busy_gpio), '0);
        chk("arst_done", DW'(done_gpio), '0);
        spi_cs_n = 1'b1;
        m_reset();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_read(7'h7F, 1);
        core_finish(rand_res());
        do_read(7'h7F, 1);
        check_state();

        repeat (4) @(negedge clk);
        chk("sb_empty", DW'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
